rd_writeback_regfile: RTL and testbench
=======================================

RD_WRITEBACK_REGFILE -- requirements
Module: rd_writeback_regfile

Interface
REQ-001 Parameter DATA_W, default 16, register data width.
REQ-002 Parameter NUM_REGS, default 16, register count; address width AW = log2(NUM_REGS) = 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 issue_valid  input  1  an instruction with destination issue_rd is issued this cycle.
REQ-006 issue_rd  input  AW  destination register of issued instruction.
REQ-007 issue_ready  output  1  issue accepted this cycle; low means WAW stall.
REQ-008 wb_valid  input  1  writeback of wb_data to wb_rd this cycle.
REQ-009 wb_rd  input  AW  writeback destination.
REQ-010 wb_data  input  DATA_W  selected Rd value, either ALU/memory result or extended immediate.
REQ-011 ra_addr, rb_addr  input  AW each  read port addresses.
REQ-012 ra_data, rb_data  output  DATA_W each  read data.
REQ-013 ra_busy, rb_busy  output  1 each  operand has an outstanding pending write.
REQ-014 wb_err  output  1  sticky flag: writeback to a non-pending register.

Function
REQ-015 Storage: NUM_REGS x DATA_W registers; R0 reads 0 always, and writes to R0 are discarded.
REQ-016 Write: on a rising edge with wb_valid=1 and wb_rd!=0, regs[wb_rd] <= wb_data.
REQ-017 Read: combinational; ra_data=regs[ra_addr], rb_data=regs[rb_addr] (0 for R0).
REQ-018 Scoreboard: pending[NUM_REGS-1:0] with pending[0] hardwired 0.
REQ-019 issue_ready = !pending[issue_rd] OR (wb_valid AND wb_rd==issue_rd), evaluated combinationally; it is 1 for issue_rd=0.
REQ-020 Set: issue_valid AND issue_ready AND issue_rd!=0 sets pending[issue_rd] at the next edge.
REQ-021 Clear: wb_valid AND wb_rd!=0 clears pending[wb_rd] at the next edge.
REQ-022 Simultaneous set and clear on the same register: set wins, so the register stays pending and the data is written.
REQ-023 issue_valid with issue_ready=0: no state change; upstream holds the instruction.
REQ-024 ra_busy = pending[ra_addr]; rb_busy = pending[rb_addr]; both are 0 for R0.
REQ-025 wb_valid with wb_rd!=0 and pending[wb_rd]=0 sets wb_err, which holds until reset; the data is still written.
REQ-026 Writes are committed at the edge; without bypass, a read in the write cycle returns the old value.

Reset
REQ-027 Asynchronous assertion of rst clears all regs to 0, all pending bits to 0, and wb_err to 0.
REQ-028 During reset, outputs are: ra_data=rb_data=0, ra_busy=rb_busy=0, issue_ready=1, wb_err=0.
REQ-029 Reset mid-operation discards all outstanding pending writes; any later wb to those registers sets wb_err.
REQ-030 Deassertion is synchronous to clk on the release path, and the first edge after deassertion is functional.

Configuration
REQ-031 Macro RF_BYPASS_EN, when defined, adds combinational write-to-read forwarding: if wb_valid AND wb_rd!=0 AND ra_addr==wb_rd, then ra_data=wb_data and ra_busy=0; rb behaves the same way.
REQ-032 With RF_BYPASS_EN undefined, there is no forwarding and REQ-026 applies.

Structure
REQ-033 A shared package holds DATA_W, AW, the NUM_REGS defaults, and the R0 index constant.
REQ-034 One sub-module, rf_scoreboard, holds pending[], issue_ready, the busy lookup, and wb_err; storage and read muxing stay in the top module.

Verification
REQ-035 Reset, then read all 16 registers: every data output reads 0x0000, every busy reads 0, issue_ready=1, and wb_err=0.
REQ-036 Issue R3, next cycle wb R3=0xBEEF: ra_addr=3 shows ra_busy=1 for one cycle, then ra_data=0xBEEF with busy=0 after the wb edge; with RF_BYPASS_EN, data=0xBEEF and busy=0 already in the wb cycle.
REQ-037 Pending R5, issue R5 with no wb: issue_ready=0 and pending is unchanged; in the same cycle wb R5=0x1234 plus issue R5 gives issue_ready=1, R5=0x1234, and R5 still pending.
REQ-038 wb R0=0xFFFF and issue R0: R0 reads 0, issue_ready=1, no busy, and wb_err stays 0.
REQ-039 wb R7=0x00AA with R7 not pending: R7=0x00AA and wb_err=1, which stays 1 until rst.
REQ-040 Issue R2, assert rst asynchronously mid-cycle: pending clears immediately and R2 reads 0; after release, wb R2 sets wb_err.

Source files
------------

// File: rtl/rd_writeback_regfile_pkg.sv
// Shared constants for the writeback register file and its scoreboard.
// Holds default data width, register count, address width and R0 index.
package rd_writeback_regfile_pkg;
   localparam int DEF_DATA_W   = 16;
   localparam int DEF_NUM_REGS = 16;
   localparam int DEF_AW       = $clog2(DEF_NUM_REGS);
   localparam int R0_IDX       = 0;
endpackage

// File: rtl/rd_writeback_regfile_if.sv
// Issue / writeback / read-port bundle for rd_writeback_regfile.
// master: pipeline side (drives issue, wb, read addresses); slave: regfile.
interface rd_writeback_regfile_if #(
   parameter int DATA_W = 16,
   parameter int AW     = 4
);
   logic              issue_valid;
   logic [AW-1:0]     issue_rd;
   logic              issue_ready;
   logic              wb_valid;
   logic [AW-1:0]     wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic [AW-1:0]     ra_addr;
   logic [AW-1:0]     rb_addr;
   logic [DATA_W-1:0] ra_data;
   logic [DATA_W-1:0] rb_data;
   logic              ra_busy;
   logic              rb_busy;
   logic              wb_err;

   modport master (
      output issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
      output ra_addr, rb_addr,
      input  issue_ready, ra_data, rb_data, ra_busy, rb_busy, wb_err
   );

   modport slave (
      input  issue_valid, issue_rd, wb_valid, wb_rd, wb_data,
      input  ra_addr, rb_addr,
      output issue_ready, ra_data, rb_data, ra_busy, rb_busy, wb_err
   );
endinterface

// File: rtl/rd_writeback_regfile_rf_scoreboard.sv
// rf_scoreboard: pending-write bits, WAW issue stall, busy lookup, wb_err.
// Ports: clk/rst, issue (valid/rd/ready), wb (valid/rd), ra/rb addr -> busy, wb_err.
module rf_scoreboard
   import rd_writeback_regfile_pkg::*;
#(
   parameter int NUM_REGS = DEF_NUM_REGS,
   parameter int AW       = $clog2(NUM_REGS)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_issue_valid,
   input  logic [AW-1:0] i_issue_rd,
   output logic          o_issue_ready,
   input  logic          i_wb_valid,
   input  logic [AW-1:0] i_wb_rd,
   input  logic [AW-1:0] i_ra_addr,
   input  logic [AW-1:0] i_rb_addr,
   output logic          o_ra_busy,
   output logic          o_rb_busy,
   output logic          o_wb_err
);
   logic [NUM_REGS-1:0] r_pending;
   logic [NUM_REGS-1:0] w_pending_nxt;
   logic                r_wb_err;
   logic                w_wb_live;
   logic                w_set;

   assign w_wb_live = i_wb_valid && (i_wb_rd != AW'(R0_IDX));

   // A writeback landing this cycle retires the pending entry, so a
   // same-register issue may proceed alongside it.
   assign o_issue_ready = !r_pending[i_issue_rd]
                        || (i_wb_valid && (i_wb_rd == i_issue_rd));

   assign w_set = i_issue_valid && o_issue_ready
                && (i_issue_rd != AW'(R0_IDX));

   // Clear first, then set, so a simultaneous set keeps the bit.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_wb_live)
         w_pending_nxt[i_wb_rd] = 1'b0;
      if (w_set)
         w_pending_nxt[i_issue_rd] = 1'b1;
      w_pending_nxt[R0_IDX] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pending <= '0;
         r_wb_err  <= 1'b0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_wb_live && !r_pending[i_wb_rd])
            r_wb_err <= 1'b1;
      end
   end

   assign o_ra_busy = r_pending[i_ra_addr];
   assign o_rb_busy = r_pending[i_rb_addr];
   assign o_wb_err  = r_wb_err;
endmodule

// File: rtl/rd_writeback_regfile.sv
// Rd writeback register file: storage, read muxing, scoreboard instance.
// Ports: clk, rst (async high), bus (rd_writeback_regfile_if.slave). Macro: RF_BYPASS_EN.
module rd_writeback_regfile
   import rd_writeback_regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic                  clk,
   input  logic                  rst,
   rd_writeback_regfile_if.slave bus
);
   localparam int AW = $clog2(NUM_REGS);

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   logic [DATA_W-1:0] w_ra_raw;
   logic [DATA_W-1:0] w_rb_raw;
   logic              w_ra_fwd;
   logic              w_rb_fwd;
   logic              w_ra_busy;
   logic              w_rb_busy;
   logic              w_wb_live;

   assign w_wb_live = bus.wb_valid && (bus.wb_rd != AW'(R0_IDX));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            r_regs[i] <= '0;
      end else if (w_wb_live) begin
         r_regs[bus.wb_rd] <= bus.wb_data;
      end
   end

   assign w_ra_raw = (bus.ra_addr == AW'(R0_IDX)) ? '0 : r_regs[bus.ra_addr];
   assign w_rb_raw = (bus.rb_addr == AW'(R0_IDX)) ? '0 : r_regs[bus.rb_addr];

`ifdef RF_BYPASS_EN
   assign w_ra_fwd = w_wb_live && (bus.ra_addr == bus.wb_rd);
   assign w_rb_fwd = w_wb_live && (bus.rb_addr == bus.wb_rd);
`else
   assign w_ra_fwd = 1'b0;
   assign w_rb_fwd = 1'b0;
`endif

   assign bus.ra_data = w_ra_fwd ? bus.wb_data : w_ra_raw;
   assign bus.rb_data = w_rb_fwd ? bus.wb_data : w_rb_raw;
   assign bus.ra_busy = w_ra_busy && !w_ra_fwd;
   assign bus.rb_busy = w_rb_busy && !w_rb_fwd;

   rf_scoreboard #(
      .NUM_REGS (NUM_REGS),
      .AW       (AW)
   ) u_sb (
      .clk           (clk),
      .rst           (rst),
      .i_issue_valid (bus.issue_valid),
      .i_issue_rd    (bus.issue_rd),
      .o_issue_ready (bus.issue_ready),
      .i_wb_valid    (bus.wb_valid),
      .i_wb_rd       (bus.wb_rd),
      .i_ra_addr     (bus.ra_addr),
      .i_rb_addr     (bus.rb_addr),
      .o_ra_busy     (w_ra_busy),
      .o_rb_busy     (w_rb_busy),
      .o_wb_err      (bus.wb_err)
   );
endmodule

// File: tb/tb_rd_writeback_regfile.sv
// Directed bench for rd_writeback_regfile.
// Drives the interface master side; checks with immediate assertions.
module tb_rd_writeback_regfile;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   rd_writeback_regfile_if #(.DATA_W(16), .AW(4)) bus ();

   rd_writeback_regfile #(.DATA_W(16), .NUM_REGS(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.issue_valid = 1'b0;
      bus.issue_rd    = 4'd0;
      bus.wb_valid    = 1'b0;
      bus.wb_rd       = 4'd0;
      bus.wb_data     = 16'h0;
   endtask

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   initial begin
      idle();
      bus.ra_addr = 4'd0;
      bus.rb_addr = 4'd0;

      // Outputs while reset held
      #12;
      bus.issue_rd = 4'd5;
      bus.ra_addr  = 4'd3;
      #1;
      chk("rst_issue_ready", 32'(bus.issue_ready), 32'd1);
      chk("rst_wb_err", 32'(bus.wb_err), 32'd0);
      chk("rst_ra_data", 32'(bus.ra_data), 32'h0);
      chk("rst_ra_busy", 32'(bus.ra_busy), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      idle();

      // All registers zero after reset
      for (int i = 0; i < 16; i++) begin
         bus.ra_addr = 4'(i);
         bus.rb_addr = 4'(15 - i);
         #1;
         chk("init_ra_data", 32'(bus.ra_data), 32'h0);
         chk("init_rb_data", 32'(bus.rb_data), 32'h0);
         chk("init_busy", 32'({bus.ra_busy, bus.rb_busy}), 32'd0);
      end
      chk("init_wb_err", 32'(bus.wb_err), 32'd0);

      // Issue R3, wb R3 next cycle
      @(negedge clk);
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 4'd3;
      bus.ra_addr     = 4'd3;
      #1;
      chk("r3_issue_ready", 32'(bus.issue_ready), 32'd1);
      chk("r3_busy_pre", 32'(bus.ra_busy), 32'd0);
      edge1();
      idle();
      #1;
      chk("r3_busy_pend", 32'(bus.ra_busy), 32'd1);
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 4'd3;
      bus.wb_data  = 16'hBEEF;
      #1;
`ifdef RF_BYPASS_EN
      chk("r3_wbcyc_busy", 32'(bus.ra_busy), 32'd0);
      chk("r3_wbcyc_data", 32'(bus.ra_data), 32'hBEEF);
`else
      chk("r3_wbcyc_busy", 32'(bus.ra_busy), 32'd1);
      chk("r3_wbcyc_data", 32'(bus.ra_data), 32'h0);
`endif
      edge1();
      idle();
      #1;
      chk("r3_post_data", 32'(bus.ra_data), 32'hBEEF);
      chk("r3_post_busy", 32'(bus.ra_busy), 32'd0);
      chk("r3_wb_err", 32'(bus.wb_err), 32'd0);

      // WAW stall on R5, then wb+issue same cycle
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 4'd5;
      bus.rb_addr     = 4'd5;
      edge1();
      chk("r5_busy", 32'(bus.rb_busy), 32'd1);
      chk("r5_stall_ready", 32'(bus.issue_ready), 32'd0);
      edge1();
      chk("r5_still_busy", 32'(bus.rb_busy), 32'd1);
      chk("r5_still_stall", 32'(bus.issue_ready), 32'd0);
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 4'd5;
      bus.wb_data  = 16'h1234;
      #1;
      chk("r5_wb_ready", 32'(bus.issue_ready), 32'd1);
      edge1();
      idle();
      #1;
      chk("r5_data", 32'(bus.rb_data), 32'h1234);
      chk("r5_repend", 32'(bus.rb_busy), 32'd1);
      chk("r5_wb_err", 32'(bus.wb_err), 32'd0);

      // R0 is inert
      bus.wb_valid    = 1'b1;
      bus.wb_rd       = 4'd0;
      bus.wb_data     = 16'hFFFF;
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 4'd0;
      bus.ra_addr     = 4'd0;
      #1;
      chk("r0_ready", 32'(bus.issue_ready), 32'd1);
      edge1();
      idle();
      #1;
      chk("r0_data", 32'(bus.ra_data), 32'h0);
      chk("r0_busy", 32'(bus.ra_busy), 32'd0);
      chk("r0_wb_err", 32'(bus.wb_err), 32'd0);

      // Unexpected wb to R7 sets sticky wb_err
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 4'd7;
      bus.wb_data  = 16'h00AA;
      bus.ra_addr  = 4'd7;
      edge1();
      idle();
      #1;
      chk("r7_data", 32'(bus.ra_data), 32'h00AA);
      chk("r7_wb_err", 32'(bus.wb_err), 32'd1);
      edge1();
      edge1();
      chk("r7_err_sticky", 32'(bus.wb_err), 32'd1);

      // Pending R2 with data, then async reset mid-cycle
      bus.issue_valid = 1'b1;
      bus.issue_rd    = 4'd2;
      bus.ra_addr     = 4'd2;
      edge1();
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 4'd2;
      bus.wb_data  = 16'h5A5A;
      edge1();
      idle();
      #1;
      chk("r2_data", 32'(bus.ra_data), 32'h5A5A);
      chk("r2_busy", 32'(bus.ra_busy), 32'd1);
      bus.issue_rd = 4'd2;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_busy", 32'(bus.ra_busy), 32'd0);
      chk("arst_data", 32'(bus.ra_data), 32'h0);
      chk("arst_wb_err", 32'(bus.wb_err), 32'd0);
      chk("arst_ready", 32'(bus.issue_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      bus.wb_valid = 1'b1;
      bus.wb_rd    = 4'd2;
      bus.wb_data  = 16'h0001;
      edge1();
      idle();
      #1;
      chk("post_rst_wb_err", 32'(bus.wb_err), 32'd1);
      chk("post_rst_data", 32'(bus.ra_data), 32'h0001);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
